// File: rtl/uart_pkg.sv
// uart_pkg: UART constants and arbiter state encoding shared by the transmit path
package uart_pkg;
    localparam int UART_DATA_W  = 8;
    localparam int CLK_FREQ     = 50_000_000;
    localparam int BAUD         = 115200;
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_TX, HOLD} arb_state_t;
endpackage

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locking arbiter sharing one UART transmitter
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid, req_last, req_data : per-requester byte offer (byte i at [8i+7:8i])
//   req_ready                     : one-hot one-cycle accept strobe
//   tx_start, tx_data, tx_done    : transmitter handshake
//   grant_id, busy, lock_abort    : current owner, not-idle flag, hold-timeout pulse
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int HOLD_TIMEOUT = 50000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_last,
    input  logic [NUM_REQ*UART_DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             tx_start,
    output logic [UART_DATA_W-1:0]           tx_data,
    input  logic                             tx_done,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id,
    output logic                             busy,
    output logic                             lock_abort
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_TIMEOUT - 1);

    arb_state_t state_q, state_d;
    logic [GW-1:0] grant_q, grant_d, rr_q, rr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic last_q, last_d, tx_start_q, tx_start_d, lock_abort_q, lock_abort_d;

    function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + GW'(1);
    endfunction

    // First valid requester scanning upward from ptr, wrapping at NUM_REQ
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [GW-1:0] ptr);
        logic [GW-1:0] idx, win;
        logic found;
        idx = ptr;
        win = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && v[idx]) begin
                win = idx;
                found = 1'b1;
            end
            idx = wrap_inc(idx);
        end
        return win;
    endfunction

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_d         = rr_q;
        last_d       = last_q;
        cnt_d        = '0;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        req_ready_d  = '0;
        lock_abort_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d = rr_pick(req_valid, rr_q);
                    state_d = LOAD;
                end
            end
            LOAD: begin
                tx_start_d  = 1'b1;
                tx_data_d   = req_data[int'(grant_q) * UART_DATA_W +: UART_DATA_W];
                req_ready_d = req_valid & (NUM_REQ'(1) << grant_q);
                last_d      = req_last[grant_q];
                state_d     = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) begin
                    state_d = last_q ? IDLE : HOLD;
                    rr_d    = last_q ? wrap_inc(grant_q) : rr_q;
                end
            end
            HOLD: begin
                if (req_valid[grant_q]) begin
                    state_d = LOAD;
                end else if (cnt_q == HOLD_MAX) begin
                    lock_abort_d = 1'b1;
                    rr_d         = wrap_inc(grant_q);
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_q         <= '0;
            last_q       <= 1'b0;
            cnt_q        <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            req_ready_q  <= '0;
            lock_abort_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_q         <= rr_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            req_ready_q  <= req_ready_d;
            lock_abort_q <= lock_abort_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign grant_id   = grant_q;
    assign busy       = state_q != IDLE;
    assign lock_abort = lock_abort_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: self-checking bench for uart_tx_arbiter with two requesters and a 16-cycle hold timeout
module tb_uart_tx_arbiter;
    import uart_pkg::*;
    localparam int FRAME    = 10 * CLKS_PER_BIT;
    localparam int FAST_D   = 5;
    localparam int HOLD_CYC = 16;

    logic clk = 1'b0, rst = 1'b1;
    logic [1:0] req_valid = '0, req_last = '0, req_ready;
    logic [15:0] req_data = '0;
    logic tx_start, tx_done = 1'b0, busy, lock_abort, txd = 1'b1;
    logic [7:0] tx_data;
    logic [0:0] grant_id;

    int n_cmp = 0, n_bad = 0;
    logic [8:0] rq [2][$];
    logic [8:0] mq [2][$];
    logic [7:0] txq [$];
    logic [63:0] log_w = '0;
    int n_log = 0;
    bit real_mode = 1'b0;
    int tx_cnt = 0;
    logic [7:0] tx_byte = '0;

    int m_rr = 0, m_own = -1, m_age = 0, cyc = 0, last_start = -1, w = 0;
    int rx_cnt = 0, rx_bit = 0, n_rx = 0;
    bit m_infl = 1'b0, m_hold = 1'b0, rx_act = 1'b0, exp_abort = 1'b0, rst_prev = 1'b1;
    logic [7:0] exp_data = '0, rx_byte = '0, e8 = '0;
    logic [8:0] e = '0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(2), .HOLD_TIMEOUT(HOLD_CYC)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .grant_id(grant_id), .busy(busy), .lock_abort(lock_abort)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            if (rq[i].size() > 0) begin
                req_valid[i]      = 1'b1;
                req_last[i]       = rq[i][0][8];
                req_data[8*i +: 8] = rq[i][0][7:0];
            end else begin
                req_valid[i]      = 1'b0;
                req_last[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
            end
        end
    endtask

    task automatic push(input int i, input logic l, input logic [7:0] d);
        rq[i].push_back({l, d});
        mq[i].push_back({l, d});
    endtask

    // One clock: requesters retire accepted bytes, transmitter model advances, inputs are re-driven
    task automatic tick();
        int b;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) if (req_ready[i] && rq[i].size() > 0) rq[i].delete(0);
        tx_done = 1'b0;
        if (tx_start) begin
            tx_cnt  = real_mode ? FRAME : FAST_D;
            tx_byte = tx_data;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
            tx_done = (tx_cnt == 0);
        end
        b   = (FRAME - tx_cnt) / CLKS_PER_BIT;
        txd = (!real_mode || tx_cnt == 0) ? 1'b1 : (b == 0) ? 1'b0 : (b <= 8) ? tx_byte[b-1] : 1'b1;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rq[i].delete();
            mq[i].delete();
        end
        drive();
        tick();
        rst   = 1'b0;
        log_w = '0;
        n_log = 0;
    endtask

    task automatic wait_start(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!tx_start && n < max);
        chk("tx_start_within_budget", tx_start, 1);
    endtask

    task automatic run_idle(input int max);
        int n;
        n = 0;
        while ((rq[0].size() > 0 || rq[1].size() > 0 || busy || tx_cnt != 0 || rx_act) && n < max) begin
            tick();
            n++;
        end
        chk("idle_within_budget", n < max, 1);
    endtask

    // Transaction-level model: who must be served next, what byte, when a stalled lock must abort
    always @(negedge clk) begin
        cyc++;
        if (rst_prev) begin
            m_rr = 0;
            m_own = -1;
            m_infl = 1'b0;
            m_hold = 1'b0;
            exp_data = '0;
            last_start = -1;
            chk("reset_busy", busy, 0);
        end
        exp_abort = 1'b0;
        if (m_hold) begin
            m_age++;
            if (m_age == HOLD_CYC + 1 && mq[m_own].size() == 0) begin
                exp_abort = 1'b1;
                m_hold = 1'b0;
                m_rr = (m_own + 1) % 2;
                m_own = -1;
            end
        end
        chk("lock_abort", lock_abort, exp_abort);
        if (tx_start) begin
            w = m_own;
            if (w < 0)
                for (int k = 0; k < 2; k++) if (w < 0 && mq[(m_rr + k) % 2].size() > 0) w = (m_rr + k) % 2;
            if (w < 0 || mq[w].size() == 0) begin
                chk("unexpected_tx_start", 1, 0);
            end else begin
                e = mq[w].pop_front();
                chk("grant_id", grant_id, w);
                chk("tx_data_at_start", tx_data, e[7:0]);
                chk("req_ready_at_start", req_ready, 2'b01 << w);
                exp_data = e[7:0];
                log_w = {log_w[55:0], e[7:0]};
                n_log++;
                if (real_mode) begin
                    txq.push_back(e[7:0]);
                    if (last_start >= 0) chk("start_gap_ge_frame", (cyc - last_start) >= FRAME, 1);
                    last_start = cyc;
                end
                m_infl = 1'b1;
                m_hold = 1'b0;
                m_own = e[8] ? -1 : w;
                if (e[8]) m_rr = (w + 1) % 2;
            end
        end else begin
            chk("req_ready_without_start", req_ready, 0);
        end
        chk("tx_data_held", tx_data, exp_data);
        if (m_infl || m_hold) chk("busy_while_owned", busy, 1);
        if (tx_done && m_infl) begin
            m_infl = 1'b0;
            if (m_own >= 0) begin
                m_hold = 1'b1;
                m_age = 0;
            end
        end
        if (real_mode) begin
            if (!rx_act) begin
                if (txd == 1'b0) begin
                    rx_act = 1'b1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % CLKS_PER_BIT == CLKS_PER_BIT / 2) begin
                    rx_bit = rx_cnt / CLKS_PER_BIT;
                    if (rx_bit >= 1 && rx_bit <= 8) rx_byte[rx_bit-1] = txd;
                    if (rx_bit == 9) begin
                        rx_act = 1'b0;
                        n_rx++;
                        chk("rx_stop_bit", txd, 1);
                        if (txq.size() == 0) begin
                            chk("rx_unexpected_byte", 1, 0);
                        end else begin
                            e8 = txq.pop_front();
                            chk("rx_byte", rx_byte, e8);
                        end
                    end
                end
            end
        end
        rst_prev = rst;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    initial begin
        int n, starts, aborts, busys;
        do_reset();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_lock_abort", lock_abort, 0);

        push(0, 1'b1, 8'h55);
        drive();
        wait_start(20, n);
        chk("start_latency", n, 2);
        chk("single_tx_data", tx_data, 8'h55);
        chk("single_req_ready", req_ready, 2'b01);
        chk("single_busy", busy, 1);
        tick();
        chk("single_ready_one_cycle", req_ready, 2'b00);
        chk("single_start_one_cycle", tx_start, 0);
        run_idle(100);
        chk("single_back_to_idle", busy, 0);
        chk("single_log", {n_log, log_w[7:0]}, {32'd1, 8'h55});

        do_reset();
        push(0, 1'b1, 8'h10);
        push(1, 1'b1, 8'h20);
        push(0, 1'b1, 8'h11);
        push(1, 1'b1, 8'h21);
        drive();
        run_idle(200);
        chk("contention_order", {n_log, log_w[31:0]}, {32'd4, 32'h10201121});

        do_reset();
        push(0, 1'b0, 8'h41);
        push(0, 1'b0, 8'h42);
        push(0, 1'b1, 8'h43);
        push(1, 1'b1, 8'hB0);
        drive();
        run_idle(200);
        chk("packet_lock_order", {n_log, log_w[31:0]}, {32'd4, 32'h414243B0});

        do_reset();
        push(0, 1'b0, 8'hA1);
        push(1, 1'b1, 8'hB1);
        drive();
        n = 0;
        while (!tx_done && n < 50) begin
            tick();
            n++;
        end
        chk("first_done_within_budget", tx_done, 1);
        n = 0;
        do begin
            tick();
            n++;
            if (n == 5) tx_done = 1'b1;
        end while (!lock_abort && n < 40);
        chk("abort_cycles_after_hold_entry", n - 1, HOLD_CYC);
        tick();
        chk("abort_single_pulse", lock_abort, 0);
        run_idle(100);
        chk("abort_then_req1", {n_log, log_w[15:0]}, {32'd2, 16'hA1B1});

        do_reset();
        push(0, 1'b0, 8'hC1);
        push(0, 1'b1, 8'hC2);
        drive();
        wait_start(20, n);
        tick();
        tick();
        chk("mid_tx_busy", busy, 1);
        do_reset();
        chk("midrst_busy", busy, 0);
        chk("midrst_tx_start", tx_start, 0);
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_tx_data", tx_data, 8'h00);
        chk("midrst_grant_id", grant_id, 0);
        chk("midrst_lock_abort", lock_abort, 0);
        starts = 0;
        aborts = 0;
        busys = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            starts += int'(tx_start);
            aborts += int'(lock_abort);
            busys += int'(busy);
        end
        chk("midrst_no_starts", starts, 0);
        chk("midrst_no_abort", aborts, 0);
        chk("midrst_stale_done_ignored", busys, 0);

        real_mode = 1'b1;
        do_reset();
        n_rx = 0;
        push(0, 1'b1, 8'h3C);
        push(0, 1'b1, 8'hA5);
        push(1, 1'b1, 8'h5A);
        push(1, 1'b1, 8'hC3);
        drive();
        run_idle(30000);
        chk("real_rate_order", {n_log, log_w[31:0]}, {32'd4, 32'h3C5AA5C3});
        chk("real_rate_rx_count", n_rx, 4);
        chk("real_rate_rx_drained", txq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
